// File: rtl/audio_buf_pkg.sv
// Shared state encoding and width constants for the audio delay scheduler.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package audio_buf_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W_DEF   = 26;
  localparam int BUF_LOG2_DEF = 20;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } state_e;

endpackage

// File: rtl/audio_delay_sched.sv
// SDRAM-backed circular audio delay line: write each sample, read it back delayed, over one Avalon master.
// Latency: 4 cycles from sample_valid to sample_out_valid, plus one per waitrequest=1 cycle.
// Backpressure: Avalon waitrequest stalls the FSM; samples arriving while busy are dropped and set sticky overrun.
// Build option SDRAM_CLEAR_EN: zero the whole buffer after reset before accepting samples.
module audio_delay_sched
  import audio_buf_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                BUF_LOG2  = BUF_LOG2_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                de10_clk_clk,
  input  logic                avalon_reset_reset,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic [BUF_LOG2-1:0] delay_words,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_out_valid,
  output logic                busy,
  output logic                overrun,
  output logic [ADDR_W-1:0]   master_controller_address,
  output logic                master_controller_read,
  output logic                master_controller_write,
  output logic [DATA_W-1:0]   master_controller_writedata,
  input  logic                master_controller_waitrequest,
  input  logic [DATA_W-1:0]   master_controller_readdata
);

  state_e              state_q;
  logic                pend_q;
  logic                busy_q;
  logic                overrun_q;
  logic [BUF_LOG2-1:0] wr_ptr_q;
  logic [BUF_LOG2-1:0] delay_q;
  logic [DATA_W-1:0]   sample_q;
  logic [ADDR_W-1:0]   address_q;
  logic                read_q;
  logic                write_q;
  logic [DATA_W-1:0]   writedata_q;
  logic [DATA_W-1:0]   sample_out_q;
  logic                sample_out_valid_q;

  logic [BUF_LOG2-1:0] wr_ptr_d;
  logic [BUF_LOG2-1:0] rd_ptr_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [ADDR_W-1:0]   nxt_addr_d;
  logic                drop_d;

  // Pointer arithmetic wraps naturally in BUF_LOG2 bits, so every address stays inside the buffer.
  // delay_words is already BUF_LOG2 bits wide, so it can never exceed BUF_WORDS-1 and needs no clamp.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + 1'b1;
    rd_ptr_d   = wr_ptr_q - delay_q;
    wr_addr_d  = BASE_ADDR + ADDR_W'(wr_ptr_q);
    rd_addr_d  = BASE_ADDR + ADDR_W'(rd_ptr_d);
    nxt_addr_d = BASE_ADDR + ADDR_W'(wr_ptr_d);
    drop_d     = sample_valid && ((state_q != ST_IDLE) || pend_q);
  end

  // Main FSM with registered Avalon and sample outputs; reset aborts any in-flight transfer.
  always_ff @(posedge de10_clk_clk or posedge avalon_reset_reset) begin
    if (avalon_reset_reset) begin
`ifdef SDRAM_CLEAR_EN
      state_q <= ST_CLEAR;
      busy_q  <= 1'b1;
`else
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
`endif
      pend_q             <= 1'b0;
      overrun_q          <= 1'b0;
      wr_ptr_q           <= '0;
      delay_q            <= '0;
      sample_q           <= '0;
      address_q          <= '0;
      read_q             <= 1'b0;
      write_q            <= 1'b0;
      writedata_q        <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
    end else begin
      sample_out_valid_q <= 1'b0;
      if (drop_d) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
`ifdef SDRAM_CLEAR_EN
        ST_CLEAR: begin
          // First cycle raises the write; afterwards each accepted write advances to the next word.
          if (!write_q) begin
            write_q     <= 1'b1;
            address_q   <= wr_addr_d;
            writedata_q <= '0;
          end else if (!master_controller_waitrequest) begin
            wr_ptr_q <= wr_ptr_d;
            if (&wr_ptr_q) begin
              write_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              address_q <= nxt_addr_d;
            end
          end
        end
`endif
        ST_IDLE: begin
          // Accept edge latches sample and delay; the following edge launches the write.
          if (pend_q) begin
            pend_q      <= 1'b0;
            write_q     <= 1'b1;
            address_q   <= wr_addr_d;
            writedata_q <= sample_q;
            busy_q      <= 1'b1;
            state_q     <= ST_WRITE;
          end else if (sample_valid) begin
            sample_q <= sample_in;
            delay_q  <= delay_words;
            pend_q   <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!master_controller_waitrequest) begin
            write_q   <= 1'b0;
            read_q    <= 1'b1;
            address_q <= rd_addr_d;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          if (!master_controller_waitrequest) begin
            read_q             <= 1'b0;
            sample_out_q       <= master_controller_readdata;
            sample_out_valid_q <= 1'b1;
            state_q            <= ST_DONE;
          end
        end
        ST_DONE: begin
          wr_ptr_q <= wr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sample_out                  = sample_out_q;
  assign sample_out_valid            = sample_out_valid_q;
  assign busy                        = busy_q;
  assign overrun                     = overrun_q;
  assign master_controller_address   = address_q;
  assign master_controller_read      = read_q;
  assign master_controller_write     = write_q;
  assign master_controller_writedata = writedata_q;

endmodule
